// File: rtl/sm4_crypt_top.sv
// SM4 block cipher engine: on-chip key expansion into a 32-entry round-key file,
// then RPC unrolled rounds per clock for encryption or decryption.

module sm4_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  // Byte 0x00 of the table sits in the most significant byte.
  localparam logic [2047:0] TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic [10:0] bit_idx;

  always_comb begin
    bit_idx  = {~in_byte, 3'b000};
    out_byte = TABLE[bit_idx +: 8];
  end
endmodule

module sm4_crypt_top #(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         mode,
  input  logic         reuse_key,
  input  logic [127:0] data,
  input  logic [127:0] mk,
  output logic [127:0] dataout,
  output logic         valid,
  output logic         busy,
  output logic         key_ready,
  output logic [1:0]   dbg_state
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
    $error("sm4_crypt_top: RPC must be 1, 2, 4 or 8");
  end

  // Handshake: start is sampled on a rising edge only while busy=0; valid is a
  // one-cycle pulse with dataout, and a start in that same cycle begins a new job.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    CRYPT  = 2'd2
  } state_e;

  localparam logic [127:0] FK      = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
  localparam logic [4:0]   RC_STEP = 5'(RPC);
  localparam logic [4:0]   RC_LAST = 5'(32 - RPC);

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  state_e       state_q, state_d;
  logic [4:0]   rc_q, rc_d;
  logic [127:0] dataout_q, dataout_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         key_ready_q, key_ready_d;

  // Working registers and round keys carry no reset; key_ready guards their use.
  logic [127:0] x_q, x_d;
  logic [127:0] k_q, k_d;
  logic         mode_q, mode_d;
  logic [31:0]  rk_q [32];
  logic [31:0]  rk_d [32];

  logic [127:0] x_chain [RPC+1];
  logic [127:0] k_chain [RPC+1];
  logic [31:0]  k_new   [RPC];

  assign x_chain[0] = x_q;
  assign k_chain[0] = k_q;

  for (genvar r = 0; r < RPC; r++) begin : g_round
    logic [4:0]  ri;
    logic [31:0] rkx, c_in, c_sb, c_t;
    logic [31:0] ck, k_in, k_sb, k_t;

    assign ri   = rc_q + 5'(r);
    assign rkx  = mode_q ? rk_q[5'd31 - ri] : rk_q[ri];
    assign c_in = x_chain[r][95:64] ^ x_chain[r][63:32] ^ x_chain[r][31:0] ^ rkx;

    for (genvar j = 0; j < 4; j++) begin : g_byte
      assign ck[31-8*j -: 8] = 8'(({3'b000, ri, 2'b00} + 10'(j)) * 10'd7);
      sm4_sbox u_sbox_c (.in_byte(c_in[8*j +: 8]), .out_byte(c_sb[8*j +: 8]));
      sm4_sbox u_sbox_k (.in_byte(k_in[8*j +: 8]), .out_byte(k_sb[8*j +: 8]));
    end

    assign c_t = c_sb ^ rotl(c_sb, 2) ^ rotl(c_sb, 10) ^ rotl(c_sb, 18) ^ rotl(c_sb, 24);
    assign x_chain[r+1] = {x_chain[r][95:0], x_chain[r][127:96] ^ c_t};

    assign k_in = k_chain[r][95:64] ^ k_chain[r][63:32] ^ k_chain[r][31:0] ^ ck;
    assign k_t  = k_sb ^ rotl(k_sb, 13) ^ rotl(k_sb, 23);
    assign k_new[r]     = k_chain[r][127:96] ^ k_t;
    assign k_chain[r+1] = {k_chain[r][95:0], k_new[r]};
  end

  always_comb begin
    state_d     = state_q;
    rc_d        = rc_q;
    dataout_d   = dataout_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    key_ready_d = key_ready_q;
    x_d         = x_q;
    k_d         = k_q;
    mode_d      = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d    = data;
          mode_d = mode;
          rc_d   = 5'd0;
          busy_d = 1'b1;
          if (reuse_key && key_ready_q) begin
            state_d = CRYPT;
          end else begin
            state_d     = KEYEXP;
            k_d         = mk ^ FK;
            key_ready_d = 1'b0;
          end
        end
      end
      KEYEXP: begin
        k_d = k_chain[RPC];
        if (rc_q == RC_LAST) begin
          state_d     = CRYPT;
          rc_d        = 5'd0;
          key_ready_d = 1'b1;
        end else begin
          rc_d = rc_q + RC_STEP;
        end
      end
      CRYPT: begin
        x_d = x_chain[RPC];
        if (rc_q == RC_LAST) begin
          // Output is the final four words in reverse order.
          dataout_d = {x_chain[RPC][31:0], x_chain[RPC][63:32],
                       x_chain[RPC][95:64], x_chain[RPC][127:96]};
          valid_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
          rc_d      = 5'd0;
        end else begin
          rc_d = rc_q + RC_STEP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rk_d = rk_q;
    if (state_q == KEYEXP) begin
      for (int r = 0; r < RPC; r++) begin
        rk_d[rc_q + 5'(r)] = k_new[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rc_q        <= 5'd0;
      dataout_q   <= 128'd0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      dataout_q   <= dataout_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      key_ready_q <= key_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q    <= x_d;
    k_q    <= k_d;
    mode_q <= mode_d;
    rk_q   <= rk_d;
  end

  assign dataout   = dataout_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign key_ready = key_ready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sm4_crypt_top.sv
// Directed bench for sm4_crypt_top: four instances (RPC 1,2,4,8) share inputs
// except start, and are checked against the published SM4 vector and round trips.

module tb_sm4_crypt_top;

  localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;
  localparam int NCYC = 70;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic [3:0]   start_v;
  logic         mode;
  logic         reuse_key;
  logic [127:0] data;
  logic [127:0] mk;
  logic [127:0] dout [4];
  logic [3:0]   valid_v, busy_v, kr_v;
  logic [1:0]   dbg_v [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sm4_crypt_top #(.RPC(1 << g)) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start_v[g]),
      .mode      (mode),
      .reuse_key (reuse_key),
      .data      (data),
      .mk        (mk),
      .dataout   (dout[g]),
      .valid     (valid_v[g]),
      .busy      (busy_v[g]),
      .key_ready (kr_v[g]),
      .dbg_state (dbg_v[g])
    );
  end

  int total = 0;
  int bad   = 0;
  int           lat  [4];
  int           nval [4];
  logic [127:0] got  [4];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one job, inputs scrambled after capture, optional extra start pulses
  task automatic run_op(input logic [3:0] smask, input logic m, input logic ru,
                        input logic [127:0] din, input logic [127:0] key,
                        input logic [3:0] pmask, input int p1, input int p2);
    for (int d = 0; d < 4; d++) begin
      lat[d] = 0; nval[d] = 0; got[d] = '0;
    end
    @(negedge clk);
    start_v = smask; mode = m; reuse_key = ru; data = din; mk = key;
    @(negedge clk);
    for (int c = 1; c <= NCYC; c++) begin
      start_v   = (c == p1 || c == p2) ? pmask : 4'b0000;
      mode      = ~m;
      reuse_key = ~ru;
      data      = {$urandom(), $urandom(), $urandom(), $urandom()};
      mk        = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (valid_v[d]) begin
          nval[d]++;
          if (lat[d] == 0) begin
            lat[d] = c;
            got[d] = dout[d];
          end
        end
      end
    end
    start_v = 4'b0000;
  endtask

  task automatic check_op(input string tag, input int base_lat, input logic chk_val,
                          input logic [127:0] expv);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_lat_rpc%0d", tag, 1 << d), 128'(lat[d]), 128'(base_lat / (1 << d)));
      check($sformatf("%s_nvalid_rpc%0d", tag, 1 << d), 128'(nval[d]), 128'd1);
      check($sformatf("%s_keyrdy_rpc%0d", tag, 1 << d), 128'(kr_v[d]), 128'd1);
      check($sformatf("%s_busy_rpc%0d", tag, 1 << d), 128'(busy_v[d]), 128'd0);
      if (chk_val) begin
        check($sformatf("%s_out_rpc%0d", tag, 1 << d), got[d], expv);
        check($sformatf("%s_hold_rpc%0d", tag, 1 << d), dout[d], expv);
      end
    end
  endtask

  task automatic b2b(input int d);
    int c1, c2;
    logic [127:0] o1;
    c1 = 0; c2 = 0; o1 = '0;
    @(negedge clk);
    start_v = 4'(1 << d); mode = 1'b0; reuse_key = 1'b1; data = PT;
    mk = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    start_v = 4'b0000;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (valid_v[d]) begin
        c1 = c;
        break;
      end
    end
    o1 = dout[d];
    start_v = 4'(1 << d); mode = 1'b1; data = CT;
    @(negedge clk);
    start_v = 4'b0000;
    check($sformatf("b2b_vdrop_rpc%0d", 1 << d), 128'(valid_v[d]), 128'd0);
    check($sformatf("b2b_busy_rpc%0d", 1 << d), 128'(busy_v[d]), 128'd1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (valid_v[d]) begin
        c2 = c;
        break;
      end
    end
    check($sformatf("b2b_lat1_rpc%0d", 1 << d), 128'(c1), 128'(32 / (1 << d)));
    check($sformatf("b2b_out1_rpc%0d", 1 << d), o1, CT);
    check($sformatf("b2b_lat2_rpc%0d", 1 << d), 128'(c2), 128'(32 / (1 << d)));
    check($sformatf("b2b_out2_rpc%0d", 1 << d), dout[d], PT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rnd_pt, rnd_key, rnd_ct;
    int seen;
    rstn = 1'b0; start_v = 4'b0000; mode = 1'b0; reuse_key = 1'b0;
    data = '0; mk = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_dout_rpc%0d", 1 << d), dout[d], 128'd0);
      check($sformatf("rst_valid_rpc%0d", 1 << d), 128'(valid_v[d]), 128'd0);
      check($sformatf("rst_busy_rpc%0d", 1 << d), 128'(busy_v[d]), 128'd0);
      check($sformatf("rst_keyrdy_rpc%0d", 1 << d), 128'(kr_v[d]), 128'd0);
    end
    rstn = 1'b1;

    // standard vector: encrypt with expansion, then decrypt reusing the keys
    run_op(4'hF, 1'b0, 1'b0, PT, PT, 4'h0, 0, 0);
    check_op("enc_exp", 64, 1'b1, CT);
    run_op(4'hF, 1'b1, 1'b1, CT, {$urandom(), $urandom(), $urandom(), $urandom()}, 4'h0, 0, 0);
    check_op("dec_reuse", 32, 1'b1, PT);

    // starts while busy on the RPC=1 instance must be ignored
    run_op(4'hF, 1'b0, 1'b0, PT, PT, 4'b0001, 5, 20);
    check_op("enc_ignstart", 64, 1'b1, CT);

    // round trip under a random key
    rnd_pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
    rnd_key = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_op(4'hF, 1'b0, 1'b0, rnd_pt, rnd_key, 4'h0, 0, 0);
    check_op("rt_enc", 64, 1'b0, '0);
    rnd_ct = got[0];
    run_op(4'hF, 1'b1, 1'b1, rnd_ct, PT, 4'h0, 0, 0);
    check_op("rt_dec", 32, 1'b1, rnd_pt);

    // reset mid-job: RPC=1 in key expansion, RPC=2 in encryption
    @(negedge clk);
    start_v = 4'b0011; mode = 1'b0; reuse_key = 1'b0; data = PT; mk = PT;
    @(negedge clk);
    start_v = 4'b0000;
    seen = 0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (valid_v[0] || valid_v[1]) seen++;
    end
    check("abort_busy0", 128'(busy_v[0]), 128'd1);
    check("abort_busy1", 128'(busy_v[1]), 128'd1);
    rstn = 1'b0;
    #1;
    check("abort_novalid", 128'(seen), 128'd0);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("abort_dout_rpc%0d", 1 << d), dout[d], 128'd0);
      check($sformatf("abort_busy_rpc%0d", 1 << d), 128'(busy_v[d]), 128'd0);
      check($sformatf("abort_keyrdy_rpc%0d", 1 << d), 128'(kr_v[d]), 128'd0);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_op(4'hF, 1'b0, 1'b1, PT, PT, 4'h0, 0, 0);
    check_op("post_rst_enc", 64, 1'b1, CT);

    for (int d = 0; d < 4; d++) b2b(d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
